// File: rtl/hub75_frame_writer.sv
// rtl/hub75_frame_writer.sv - raster pixel stream to double-buffered HUB75 frame RAM writer
// Owns the display buffer select and swaps it only on a scan frame boundary.
module hub75_frame_writer #(
  parameter int COLS  = 128,
  parameter int ROWS  = 32,
  parameter int LANES = 4,
  parameter int BPC   = 8,
  localparam int COL_W  = $clog2(COLS),
  localparam int ROW_W  = $clog2(ROWS),
  localparam int Y_W    = $clog2(LANES * ROWS),
  localparam int PIX_W  = 3 * BPC,
  localparam int ADDR_W = 1 + ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sof,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              scan_frame_start,
  output logic              disp_buf,
  output logic [LANES-1:0]  wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        sync_err_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(LANES * ROWS - 1);

  state_t              state_q, state_d;
  logic [COL_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic                disp_q, disp_d;
  logic [15:0]         frame_q, frame_d;
  logic [7:0]          err_q, err_d;
  logic [LANES-1:0]    wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]    wr_data_q, wr_data_d;

  logic                accept;
  logic                do_wr;
  logic                err_inc;
  logic [COL_W-1:0]    wx;
  logic [Y_W-1:0]      wy;

  // Ready is a function of state alone so upstream never sees a valid->ready path.
  assign s_ready = (state_q == IDLE) || (state_q == WRITE);
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    disp_d    = disp_q;
    frame_d   = frame_q;
    err_d     = err_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    do_wr     = 1'b0;
    err_inc   = 1'b0;
    wx        = x_q;
    wy        = y_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (s_sof) begin
            do_wr   = 1'b1;
            wx      = '0;
            wy      = '0;
            state_d = WRITE;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      WRITE: begin
        if (accept) begin
          do_wr = 1'b1;
          // A mid-frame SOF resynchronises: restart the frame at this pixel.
          if (s_sof) begin
            err_inc = 1'b1;
            wx      = '0;
            wy      = '0;
          end
        end
      end
      WAIT_SWAP: begin
        if (scan_frame_start) begin
          disp_d  = ~disp_q;
          frame_d = frame_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_wr) begin
      wr_en_d   = LANES'(1) << wy[Y_W-1:ROW_W];
      wr_addr_d = {~disp_q, wy[ROW_W-1:0], wx};
      wr_data_d = s_data;
      if (wx == COL_MAX) begin
        x_d = '0;
        if (wy == Y_MAX) begin
          y_d     = '0;
          state_d = WAIT_SWAP;
        end else begin
          y_d = wy + 1'b1;
        end
      end else begin
        x_d = wx + 1'b1;
        y_d = wy;
      end
    end

    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      disp_q    <= 1'b0;
      frame_q   <= '0;
      err_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      disp_q    <= disp_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign disp_buf     = disp_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_cnt    = frame_q;
  assign sync_err_cnt = err_q;

endmodule

// File: tb/tb_hub75_frame_writer.sv
// tb/tb_hub75_frame_writer.sv - scoreboard bench for hub75_frame_writer
`timescale 1ns/1ps
module tb_hub75_frame_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_sof = 1'b0;
  logic [23:0] s_data = '0;
  logic        scan_frame_start = 1'b0;
  logic        disp_buf;
  logic [3:0]  wr_en;
  logic [12:0] wr_addr;
  logic [23:0] wr_data;
  logic [15:0] frame_cnt;
  logic [7:0]  sync_err_cnt;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  logic [40:0] exp_q[$];

  hub75_frame_writer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_data(s_data), .scan_frame_start(scan_frame_start), .disp_buf(disp_buf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_cnt(frame_cnt),
    .sync_err_cnt(sync_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    logic [40:0] e;
    if (wr_en !== 4'b0000) begin
      wr_pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got en=%b addr=%h data=%h, required no write",
                 wr_en, wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_en, wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write: got en=%b addr=%h data=%h, required en=%b addr=%h data=%h",
                   wr_en, wr_addr, wr_data, e[40:37], e[36:24], e[23:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input logic [23:0] d, input logic sof, input logic exp_wr,
                      input logic [3:0] een, input logic [12:0] eaddr);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready=0, required 1");
    end else if (exp_wr) begin
      exp_q.push_back({een, eaddr, d});
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic msb, input bit gaps, input int resof_at,
                       input int swap_at, input int npix);
    int pos = 0;
    int k = 0;
    logic [3:0]  een;
    logic [12:0] ea;
    while (pos < npix) begin
      if (k == resof_at) pos = 0;
      if (gaps && $urandom_range(0, 9) < 3) idle(1);
      een = 4'b0001 << (pos / 4096);
      ea  = {msb, 5'((pos / 128) % 32), 7'(pos % 128)};
      // Hand-derived corner addresses of the 4x32x128 map.
      if (pos == 0)     begin een = 4'b0001; ea = {msb, 12'h000}; end
      if (pos == 4095)  begin een = 4'b0001; ea = {msb, 12'hFFF}; end
      if (pos == 4096)  begin een = 4'b0010; ea = {msb, 12'h000}; end
      if (pos == 16383) begin een = 4'b1000; ea = {msb, 12'hFFF}; end
      scan_frame_start = (k == swap_at);
      send(24'(k), (k == 0) || (k == resof_at), 1'b1, een, ea);
      scan_frame_start = 1'b0;
      pos++;
      k++;
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_reset_state();
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_disp_buf", 32'(disp_buf), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_sync_err", 32'(sync_err_cnt), 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_reset_state();

    // 1: full frame into buffer 1, swap pulse coinciding with last pixel is ignored
    frame(1'b1, 1'b0, -1, 16383, 16384);
    idle(2);
    chk("t1_s_ready_wait", 32'(s_ready), 32'd0);
    chk("t1_disp_buf", 32'(disp_buf), 32'd0);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd0);

    // 2: swap
    scan_frame_start = 1'b1;
    @(negedge clk);
    scan_frame_start = 1'b0;
    chk("t2_disp_buf", 32'(disp_buf), 32'd1);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t2_s_ready", 32'(s_ready), 32'd1);

    // 3: gapped frame into buffer 0, swap pulse mid-frame ignored
    base = wr_pulses;
    frame(1'b0, 1'b1, -1, 5000, 16384);
    idle(2);
    chk("t3_write_count", 32'(wr_pulses - base), 32'd16384);
    chk("t3_disp_unchanged", 32'(disp_buf), 32'd1);
    chk("t3_s_ready_wait", 32'(s_ready), 32'd0);
    scan_frame_start = 1'b1;
    @(negedge clk);
    scan_frame_start = 1'b0;
    chk("t3_disp_buf", 32'(disp_buf), 32'd0);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd2);

    // 4: resync SOF on pixel 100
    base = wr_pulses;
    frame(1'b1, 1'b0, 100, -1, 16384);
    idle(2);
    chk("t4_sync_err", 32'(sync_err_cnt), 32'd1);
    chk("t4_write_count", 32'(wr_pulses - base), 32'd16484);
    chk("t4_s_ready_wait", 32'(s_ready), 32'd0);

    // 5: stray pixels in IDLE, then swap request during WRITE
    do_reset();
    chk_reset_state();
    for (int i = 0; i < 5; i++) send(24'(i + 100), 1'b0, 1'b0, 4'b0, 13'b0);
    idle(2);
    chk("t5_sync_err", 32'(sync_err_cnt), 32'd5);
    chk("t5_s_ready_idle", 32'(s_ready), 32'd1);
    frame(1'b1, 1'b0, -1, 50, 2000);
    idle(1);
    chk("t5_disp_unchanged", 32'(disp_buf), 32'd0);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd0);

    // 6: reset mid-frame, then a new frame restarts at {1,0,0}
    do_reset();
    chk_reset_state();
    frame(1'b1, 1'b0, -1, -1, 10);
    idle(3);
    chk("t6_sync_err", 32'(sync_err_cnt), 32'd0);
    chk("t6_pending", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
